// File: rtl/door_lock_pkg.sv
// Shared types and constants for the door lock controller.
// The optional programming port is enabled with DOOR_LOCK_PROG_EN.
package door_lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_LOCKOUT = 3'd4
   } dl_state_e;

   localparam int DL_CODE_W       = 16;
   // Fill bit of the default passcode: every bit of the code takes this value.
   localparam bit DL_DEFAULT_FILL = 1'b1;

endpackage

// File: rtl/door_lock_timer.sv
// Down-counter shared by the OPEN and LOCKOUT durations.
// Load wins over count; done is asserted while the count sits at zero.
module door_lock_timer #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/door_lock_ctrl.sv
// Passcode door lock: accept, check, open or count failures, lock out after MAX_TRIES.
// Define DOOR_LOCK_PROG_EN to add the passcode reprogramming port.
module door_lock_ctrl
   import door_lock_pkg::*;
#(
   parameter int                 CODE_W      = DL_CODE_W,
   parameter int                 MAX_TRIES   = 3,
   parameter int                 LOCKOUT_CYC = 1024,
   parameter int                 OPEN_CYC    = 256,
   parameter logic [CODE_W-1:0]  RESET_CODE  = {CODE_W{DL_DEFAULT_FILL}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] code,
   output logic              code_ready,
   output logic              unlock,
   output logic              fail,
   output logic              locked_out,
   output logic [2:0]        tries_left
`ifdef DOOR_LOCK_PROG_EN
   ,
   input  logic              prog_valid,
   input  logic [CODE_W-1:0] prog_old,
   input  logic [CODE_W-1:0] prog_new,
   output logic              prog_ack
`endif
);

   localparam int MAX_CYC = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
   localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYC - 1);
   localparam logic [2:0]       TRIES     = 3'(MAX_TRIES);

   dl_state_e         state_q, state_d;
   logic [2:0]        fcnt_q, fcnt_d;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [CODE_W-1:0] stored_code;
   logic              match;

   logic              tmr_load, tmr_en, tmr_done;
   logic [CNT_W-1:0]  tmr_val, tmr_cnt;

`ifdef DOOR_LOCK_PROG_EN
   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] newc_q, newc_d;
   logic              is_prog_q, is_prog_d;
   logic              ack_q, ack_d;

   assign stored_code = code_q;
   assign prog_ack    = ack_q;
`else
   assign stored_code = RESET_CODE;
`endif

   assign match = (cand_q == stored_code);

   door_lock_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .done_o     (tmr_done),
      .cnt_o      (tmr_cnt)
   );

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      cand_d   = cand_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;
`ifdef DOOR_LOCK_PROG_EN
      code_d    = code_q;
      newc_d    = newc_q;
      is_prog_d = is_prog_q;
      ack_d     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            // A code attempt always beats a programming request in the same cycle.
            if (code_valid) begin
               cand_d  = code;
               state_d = ST_CHECK;
`ifdef DOOR_LOCK_PROG_EN
               is_prog_d = 1'b0;
            end else if (prog_valid) begin
               cand_d    = prog_old;
               newc_d    = prog_new;
               is_prog_d = 1'b1;
               state_d   = ST_CHECK;
`endif
            end
         end
         ST_CHECK: begin
            if (match) begin
               fcnt_d = '0;
`ifdef DOOR_LOCK_PROG_EN
               if (is_prog_q) begin
                  code_d  = newc_q;
                  ack_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmr_load = 1'b1;
                  tmr_val  = OPEN_LOAD;
                  state_d  = ST_OPEN;
               end
`else
               tmr_load = 1'b1;
               tmr_val  = OPEN_LOAD;
               state_d  = ST_OPEN;
`endif
            end else if (fcnt_q >= TRIES - 3'd1) begin
               fcnt_d   = TRIES;
               tmr_load = 1'b1;
               tmr_val  = LOCK_LOAD;
               state_d  = ST_LOCKOUT;
            end else begin
               fcnt_d  = fcnt_q + 3'd1;
               state_d = ST_FAIL;
            end
         end
         ST_OPEN: begin
            if (tmr_done) state_d = ST_IDLE;
            else          tmr_en  = 1'b1;
         end
         ST_FAIL: state_d = ST_IDLE;
         ST_LOCKOUT: begin
            if (tmr_done) begin
               fcnt_d  = '0;
               state_d = ST_IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         cand_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         cand_q  <= cand_d;
      end
   end

`ifdef DOOR_LOCK_PROG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q    <= RESET_CODE;
         newc_q    <= '0;
         is_prog_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         code_q    <= code_d;
         newc_q    <= newc_d;
         is_prog_q <= is_prog_d;
         ack_q     <= ack_d;
      end
   end
`endif

   // The lockout entry cycle is the one where the timer still holds its load value.
   assign code_ready = (state_q == ST_IDLE);
   assign unlock     = (state_q == ST_OPEN);
   assign locked_out = (state_q == ST_LOCKOUT);
   assign fail       = (state_q == ST_FAIL) ||
                       ((state_q == ST_LOCKOUT) && (tmr_cnt == LOCK_LOAD));
   assign tries_left = TRIES - fcnt_q;

endmodule

// File: doc/door_lock_ctrl.md
DOOR_LOCK_CTRL -- requirements
Module: door_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, 16, passcode width in bits.
REQ-002 SHALL have parameter MAX_TRIES, 3, consecutive failures that trigger lockout (1..7).
REQ-003 SHALL have parameter LOCKOUT_CYC, 1024, lockout duration in clk cycles (>=2).
REQ-004 SHALL have parameter OPEN_CYC, 256, unlock hold time in clk cycles (>=1).
REQ-005 SHALL have parameter RESET_CODE, all-ones, stored code after reset.
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port code_valid  in  1  entry attempt present.
REQ-009 SHALL have port code  in  CODE_W  entered passcode.
REQ-010 SHALL have port code_ready  out  1  controller accepts an attempt.
REQ-011 SHALL have port unlock  out  1  door-open drive.
REQ-012 SHALL have port fail  out  1  one-cycle pulse per rejected attempt.
REQ-013 SHALL have port locked_out  out  1  lockout active.
REQ-014 SHALL have port tries_left  out  3  remaining attempts before lockout.

Function
REQ-015 SHALL implement an FSM with states IDLE, CHECK, OPEN, FAIL and LOCKOUT.
REQ-016 SHALL drive code_ready=1 only in IDLE; an attempt is accepted on code_valid&code_ready, with code registered that cycle.
REQ-017 SHALL move IDLE->CHECK on acceptance and otherwise hold IDLE.
REQ-018 SHALL, in CHECK (exactly one cycle), compare the registered code with the stored code over the full CODE_W bits.
REQ-019 SHALL, on match, go to OPEN, clear the fail count, and assert unlock for exactly OPEN_CYC cycles, first asserted 2 cycles after the accepting edge, then return to IDLE.
REQ-020 SHALL, on mismatch, increment the fail count; if the count reaches MAX_TRIES go to LOCKOUT, otherwise go to FAIL.
REQ-021 SHALL, in FAIL, pulse fail for exactly one cycle, then return to IDLE.
REQ-022 SHALL, on the final failure, also pulse fail on LOCKOUT entry, hold locked_out=1 for exactly LOCKOUT_CYC cycles, then clear the fail count and return to IDLE.
REQ-023 SHALL drive tries_left = MAX_TRIES - fail count, which reads 0 throughout LOCKOUT.
REQ-024 SHALL ignore code_valid outside IDLE; no attempt is queued.
REQ-025 SHALL NOT let the fail count wrap: it saturates at MAX_TRIES.
REQ-026 SHALL implement the OPEN and LOCKOUT durations with one shared down-counter, loaded on state entry.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-OPEN or mid-LOCKOUT, immediately force: state IDLE, unlock=0, fail=0, locked_out=0, tries_left=MAX_TRIES, counter 0, stored code=RESET_CODE.
REQ-028 SHALL, after rst_n deasserts, raise code_ready in the first cycle.

Configuration
REQ-029 SHALL, with DOOR_LOCK_PROG_EN defined, add ports prog_valid in 1, prog_old in CODE_W, prog_new in CODE_W and prog_ack out 1.
REQ-030 SHALL, under that macro, accept prog_valid only in IDLE and only when code_valid is low (code_valid has priority), then go through CHECK comparing prog_old.
REQ-031 SHALL, under that macro, on a prog_old match load prog_new as the stored code, pulse prog_ack for one cycle, leave unlock=0, clear the fail count, and return to IDLE; on a mismatch, treat it as a failed attempt (REQ-020).
REQ-032 SHALL, without DOOR_LOCK_PROG_EN, omit these ports and hold the stored code as the constant RESET_CODE.

Structure
REQ-033 SHALL place the state enum type and a default-code constant in package door_lock_pkg.
REQ-034 SHALL implement the duration counter as sub-module door_lock_timer (load, count, done).

Verification
REQ-035 SHALL cover: after reset, code=16'hFFFF for 1 cycle -> unlock high 2 cycles later, for exactly 256 cycles, tries_left=3.
REQ-036 SHALL cover: 2 wrong codes then the right code -> fail pulses twice, tries_left 3->2->1->3, unlock asserted.
REQ-037 SHALL cover: 3 wrong codes -> locked_out high 1024 cycles, code_valid during lockout ignored (code_ready=0), then tries_left=3.
REQ-038 SHALL cover: rst_n low at cycle 100 of OPEN -> unlock drops that cycle and code_ready=1 after release.
REQ-039 SHALL cover, with DOOR_LOCK_PROG_EN: prog_old=FFFF, prog_new=1234 -> prog_ack pulse; then code=FFFF fails and code=1234 unlocks.
REQ-040 SHALL cover, with DOOR_LOCK_PROG_EN: code_valid and prog_valid in the same IDLE cycle -> code is checked first and prog is not acknowledged that cycle.
